// File: rtl/keccak_pad.sv
// SHA3-256 input stage: packs a 64-bit little-endian word stream into 17-lane rate
// blocks, applies pad10*1 with a domain byte, and hands full 5x5 states downstream.
module keccak_pad #(
    parameter int         WIDTH      = 64,
    parameter int         RATE_LANES = 17,
    parameter logic [7:0] DOMAIN     = 8'h06
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [WIDTH-1:0]              in_data,
    input  logic [3:0]                    in_bytes,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [0:4][0:4][WIDTH-1:0]    out_block,
    output logic                          out_valid,
    output logic                          out_last,
    input  logic                          out_ready
);

    localparam int RB = 8 * RATE_LANES;
    localparam int PW = 8;
    localparam int CW = 5;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        EMIT   = 2'd1,
        PADBLK = 2'd2
    } state_t;

    state_t                             state_q, state_d;
    logic [CW-1:0]                      lane_cnt_q, lane_cnt_d;
    logic                               pad_pending_q, pad_pending_d;
    logic [RATE_LANES-1:0][WIDTH-1:0]   buf_q, buf_d;
    logic                               out_last_q, out_last_d;
    logic                               out_valid_q, out_valid_d;
    logic                               in_ready_q, in_ready_d;

    logic [3:0]                         nbytes;
    logic [WIDTH-1:0]                   masked_word;
    logic [PW-1:0]                      pad_pos;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= FILL;
            lane_cnt_q    <= '0;
            pad_pending_q <= 1'b0;
            buf_q         <= '0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_cnt_q    <= lane_cnt_d;
            pad_pending_q <= pad_pending_d;
            buf_q         <= buf_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
        end
    end

    // Non-final words always carry 8 bytes; a final word's count saturates at 8.
    always_comb begin
        nbytes = 4'd8;
        if (in_last && (in_bytes < 4'd8))
            nbytes = in_bytes;
        masked_word = '0;
        for (int b = 0; b < 8; b++)
            masked_word[8*b +: 8] = (4'(b) < nbytes) ? in_data[8*b +: 8] : 8'h00;
        pad_pos = {lane_cnt_q, 3'b000} + PW'(nbytes);
    end

    always_comb begin
        state_d       = state_q;
        lane_cnt_d    = lane_cnt_q;
        pad_pending_d = pad_pending_q;
        buf_d         = buf_q;
        out_last_d    = out_last_q;

        case (state_q)
            FILL: begin
                if (in_valid && in_ready_q) begin
                    buf_d[lane_cnt_q] = masked_word;
                    if (in_last) begin
                        state_d = EMIT;
                        if (pad_pos < PW'(RB)) begin
                            // Bytes past the message are already zero, so only the
                            // domain byte and the final 0x80 bit need writing.
                            for (int l = 0; l < RATE_LANES; l++)
                                for (int b = 0; b < 8; b++)
                                    if (pad_pos == PW'(8*l + b))
                                        buf_d[l][8*b +: 8] = DOMAIN;
                            buf_d[RATE_LANES-1][WIDTH-1 -: 8] =
                                buf_d[RATE_LANES-1][WIDTH-1 -: 8] | 8'h80;
                            out_last_d = 1'b1;
                        end else begin
                            out_last_d    = 1'b0;
                            pad_pending_d = 1'b1;
                        end
                    end else if (lane_cnt_q == CW'(RATE_LANES - 1)) begin
                        state_d    = EMIT;
                        out_last_d = 1'b0;
                    end else begin
                        lane_cnt_d = lane_cnt_q + CW'(1);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    buf_d      = '0;
                    lane_cnt_d = '0;
                    out_last_d = 1'b0;
                    if (pad_pending_q) begin
                        state_d       = PADBLK;
                        pad_pending_d = 1'b0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            PADBLK: begin
                buf_d                              = '0;
                buf_d[0][7:0]                      = DOMAIN;
                buf_d[RATE_LANES-1][WIDTH-1 -: 8]  = 8'h80;
                out_last_d                         = 1'b1;
                state_d                            = EMIT;
            end
            default: state_d = FILL;
        endcase

        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == EMIT);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    // Lane k sits at [k%5][k/5]; capacity lanes are tied to zero.
    for (genvar gi = 0; gi < 25; gi++) begin : g_lane
        if (gi < RATE_LANES) begin : g_rate
            assign out_block[gi % 5][gi / 5] = buf_q[gi];
        end else begin : g_cap
            assign out_block[gi % 5][gi / 5] = '0;
        end
    end

endmodule

// File: tb/tb_keccak_pad.sv
// Randomized bench for keccak_pad: messages are padded by a byte-level pad10*1 model
// and every emitted block, flag and handshake timing is compared against it.
module tb_keccak_pad;

    typedef logic [24:0][63:0] blk_t;

    logic                       clk = 1'b0;
    logic                       nrst = 1'b0;
    logic [63:0]                in_data = '0;
    logic [3:0]                 in_bytes = '0;
    logic                       in_valid = 1'b0;
    logic                       in_last = 1'b0;
    logic                       in_ready;
    logic [0:4][0:4][63:0]      out_block;
    logic                       out_valid;
    logic                       out_last;
    logic                       out_ready = 1'b0;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   t_in = 0;

    blk_t obs_q[$];
    bit   obs_last_q[$];
    int   obs_t_q[$];
    blk_t exp_q[$];
    bit   exp_last_q[$];

    keccak_pad dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_block (out_block),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic blk_t grab();
        blk_t b;
        for (int k = 0; k < 25; k++) b[k] = out_block[k % 5][k / 5];
        return b;
    endfunction

    function automatic int first_diff(input blk_t a, input blk_t b);
        for (int k = 0; k < 25; k++) if (a[k] !== b[k]) return k;
        return 0;
    endfunction

    function automatic blk_t pad_only_blk();
        blk_t b = '0;
        b[0]  = 64'h0000000000000006;
        b[16] = 64'h8000000000000000;
        return b;
    endfunction

    // Byte-level pad10*1: append 0x06, zero-fill to a 136-byte multiple, OR 0x80 into the end.
    function automatic void model(input byte unsigned msg[$]);
        byte unsigned p[$];
        int nblk;
        p = msg;
        p.push_back(8'h06);
        while (p.size() % 136 != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        nblk = p.size() / 136;
        exp_q.delete();
        exp_last_q.delete();
        for (int bk = 0; bk < nblk; bk++) begin
            blk_t b = '0;
            for (int j = 0; j < 136; j++) b[j/8][8*(j%8) +: 8] = p[136*bk + j];
            exp_q.push_back(b);
            exp_last_q.push_back(bk == nblk - 1);
        end
    endfunction

    task automatic exchange(input byte unsigned msg[$], input int rdy_pct);
        int nw;
        int nexp;
        bit to_drv = 1'b0;
        bit to_col = 1'b0;
        obs_q.delete();
        obs_last_q.delete();
        obs_t_q.delete();
        nexp = msg.size() / 136 + 1;
        nw = (msg.size() == 0) ? 1 : (msg.size() + 7) / 8;
        fork
            begin
                for (int w = 0; w < nw; w++) begin
                    logic [63:0] d;
                    int nb;
                    bit acc;
                    int guard;
                    d = {$urandom, $urandom};
                    nb = msg.size() - 8*w;
                    if (nb > 8) nb = 8;
                    for (int i = 0; i < nb; i++) d[8*i +: 8] = msg[8*w + i];
                    if (rdy_pct < 100 && $urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    in_data  = d;
                    in_valid = 1'b1;
                    in_last  = (w == nw - 1);
                    if (w == nw - 1)
                        in_bytes = (nb == 8) ? 4'($urandom_range(8, 15)) : 4'(nb);
                    else
                        in_bytes = 4'($urandom_range(0, 15));
                    guard = 0;
                    do begin
                        acc = in_ready;
                        @(posedge clk); #1;
                        guard++;
                    end while (!acc && guard < 4000);
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                    if (!acc) begin
                        to_drv = 1'b1;
                        break;
                    end
                end
                t_in = cyc;
            end
            begin
                int guard = 0;
                while (obs_q.size() < nexp && guard < 4000) begin
                    out_ready = ($urandom_range(0, 99) < rdy_pct);
                    if (out_valid && out_ready) begin
                        obs_q.push_back(grab());
                        obs_last_q.push_back(out_last);
                        obs_t_q.push_back(cyc);
                    end
                    @(posedge clk); #1;
                    guard++;
                end
                out_ready = 1'b0;
                if (obs_q.size() < nexp) to_col = 1'b1;
            end
        join
        total++;
        if (to_drv || to_col) begin
            bad++;
            $display("FAIL exchange_timeout len=%0d got_blocks=%0d need_blocks=%0d", msg.size(), obs_q.size(), nexp);
        end
        $display("msg len=%0d blocks=%0d ready_pct=%0d", msg.size(), obs_q.size(), rdy_pct);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            bad++; $display("FAIL reset_out_flags got valid=%b last=%b exp=0,0", out_valid, out_last);
        end
        total++;
        if (grab() !== '0) begin bad++; $display("FAIL reset_out_block got lane%0d nonzero exp=0", first_diff(grab(), '0)); end
        nrst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_release_early got in_ready=%b exp=0", in_ready); end
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release got in_ready=%b out_valid=%b exp=1,0", in_ready, out_valid);
        end
    endtask

    task automatic test_empty();
        byte unsigned msg[$];
        blk_t e = pad_only_blk();
        exchange(msg, 100);
        total++;
        if (obs_q.size() !== 1) begin
            bad++; $display("FAIL empty_count got=%0d exp=1", obs_q.size());
        end else begin
            total++;
            if (obs_q[0] !== e) begin
                bad++; $display("FAIL empty_block lane%0d got=%h exp=%h", first_diff(obs_q[0], e),
                                obs_q[0][first_diff(obs_q[0], e)], e[first_diff(obs_q[0], e)]);
            end
            total++;
            if (obs_last_q[0] !== 1'b1) begin bad++; $display("FAIL empty_last got=%b exp=1", obs_last_q[0]); end
            total++;
            if (obs_t_q[0] !== t_in) begin bad++; $display("FAIL empty_latency got=%0d exp=%0d", obs_t_q[0], t_in); end
        end
    endtask

    task automatic test_abc();
        byte unsigned msg[$] = '{8'h61, 8'h62, 8'h63};
        blk_t e = '0;
        e[0]  = 64'h0000000006636261;
        e[16] = 64'h8000000000000000;
        exchange(msg, 100);
        total++;
        if (obs_q.size() !== 1) begin
            bad++; $display("FAIL abc_count got=%0d exp=1", obs_q.size());
        end else begin
            total++;
            if (obs_q[0] !== e || obs_last_q[0] !== 1'b1) begin
                bad++; $display("FAIL abc_block lane%0d got=%h exp=%h last=%b", first_diff(obs_q[0], e),
                                obs_q[0][first_diff(obs_q[0], e)], e[first_diff(obs_q[0], e)], obs_last_q[0]);
            end
        end
    endtask

    task automatic test_lane16_pad();
        byte unsigned msg[$];
        byte unsigned tail[7] = '{8'h11, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        for (int i = 0; i < 128; i++) msg.push_back(8'($urandom));
        for (int i = 0; i < 7; i++) msg.push_back(tail[i]);
        model(msg);
        exchange(msg, 100);
        total++;
        if (obs_q.size() !== 1) begin
            bad++; $display("FAIL lane16_count got=%0d exp=1", obs_q.size());
        end else begin
            total++;
            if (obs_q[0][16] !== 64'h86AABBCCDDEEFF11 || obs_last_q[0] !== 1'b1) begin
                bad++; $display("FAIL lane16_value got=%h last=%b exp=86aabbccddeeff11 last=1", obs_q[0][16], obs_last_q[0]);
            end
            total++;
            if (obs_q[0] !== exp_q[0]) begin
                bad++; $display("FAIL lane16_block lane%0d got=%h exp=%h", first_diff(obs_q[0], exp_q[0]),
                                obs_q[0][first_diff(obs_q[0], exp_q[0])], exp_q[0][first_diff(obs_q[0], exp_q[0])]);
            end
        end
    endtask

    task automatic test_boundary();
        byte unsigned msg[$];
        blk_t e = pad_only_blk();
        for (int i = 0; i < 136; i++) msg.push_back(8'($urandom));
        model(msg);
        exchange(msg, 100);
        total++;
        if (obs_q.size() !== 2) begin
            bad++; $display("FAIL boundary_count got=%0d exp=2", obs_q.size());
        end else begin
            total++;
            if (obs_q[0] !== exp_q[0] || obs_last_q[0] !== 1'b0) begin
                bad++; $display("FAIL boundary_first lane%0d got=%h exp=%h last=%b exp_last=0", first_diff(obs_q[0], exp_q[0]),
                                obs_q[0][first_diff(obs_q[0], exp_q[0])], exp_q[0][first_diff(obs_q[0], exp_q[0])], obs_last_q[0]);
            end
            total++;
            if (obs_t_q[1] !== obs_t_q[0] + 2) begin
                bad++; $display("FAIL boundary_gap got=%0d exp=2", obs_t_q[1] - obs_t_q[0]);
            end
            total++;
            if (obs_q[1] !== e || obs_last_q[1] !== 1'b1) begin
                bad++; $display("FAIL boundary_padblk lane%0d got=%h exp=%h last=%b", first_diff(obs_q[1], e),
                                obs_q[1][first_diff(obs_q[1], e)], e[first_diff(obs_q[1], e)], obs_last_q[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        byte unsigned msg[$];
        byte unsigned abc[$] = '{8'h61, 8'h62, 8'h63};
        blk_t snap;
        blk_t e = '0;
        bit stuck = 1'b0;
        out_ready = 1'b0;
        for (int w = 0; w < 17 && !stuck; w++) begin
            logic [63:0] d;
            bit acc;
            int guard = 0;
            d = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) msg.push_back(d[8*i +: 8]);
            in_data = d; in_valid = 1'b1; in_last = 1'b0; in_bytes = 4'($urandom_range(0, 15));
            do begin
                acc = in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!acc && guard < 100);
            if (!acc) stuck = 1'b1;
        end
        total++;
        if (stuck) begin bad++; $display("FAIL bp_fill_timeout got in_ready=0 exp=1"); end
        in_data = {$urandom, $urandom};
        model(msg);
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_emit got valid=%b in_ready=%b exp=1,0", out_valid, in_ready);
        end
        snap = grab();
        total++;
        if (snap !== exp_q[0] || out_last !== 1'b0) begin
            bad++; $display("FAIL bp_block lane%0d got=%h exp=%h last=%b", first_diff(snap, exp_q[0]),
                            snap[first_diff(snap, exp_q[0])], exp_q[0][first_diff(snap, exp_q[0])], out_last);
        end
        for (int c = 0; c < 5; c++) begin
            in_data = {$urandom, $urandom};
            @(posedge clk); #1;
            total++;
            if (grab() !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold cycle=%0d got valid=%b in_ready=%b block_same=%b exp 1,0,1", c,
                                out_valid, in_ready, grab() === snap);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_return got in_ready=%b out_valid=%b exp=1,0", in_ready, out_valid);
        end
        e[0]  = 64'h0000000006636261;
        e[16] = 64'h8000000000000000;
        exchange(abc, 100);
        total++;
        if (obs_q.size() !== 1 || obs_q[0] !== e) begin
            bad++; $display("FAIL bp_next_msg got blocks=%0d exp 1 abc block", obs_q.size());
        end
    endtask

    task automatic test_reset_midfill();
        byte unsigned abc[$] = '{8'h61, 8'h62, 8'h63};
        blk_t e = '0;
        for (int w = 0; w < 9; w++) begin
            bit acc;
            int guard = 0;
            in_data = {$urandom, $urandom} | 64'h1; in_valid = 1'b1; in_last = 1'b0; in_bytes = 4'd8;
            do begin
                acc = in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!acc && guard < 100);
        end
        #2;
        nrst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || grab() !== '0) begin
            bad++; $display("FAIL midfill_reset got in_ready=%b valid=%b last=%b block_zero=%b exp 0,0,0,1",
                            in_ready, out_valid, out_last, grab() === '0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        e[0]  = 64'h0000000006636261;
        e[16] = 64'h8000000000000000;
        exchange(abc, 100);
        total++;
        if (obs_q.size() !== 1) begin
            bad++; $display("FAIL midfill_abc_count got=%0d exp=1", obs_q.size());
        end else begin
            total++;
            if (obs_q[0] !== e || obs_last_q[0] !== 1'b1) begin
                bad++; $display("FAIL midfill_abc lane%0d got=%h exp=%h", first_diff(obs_q[0], e),
                                obs_q[0][first_diff(obs_q[0], e)], e[first_diff(obs_q[0], e)]);
            end
        end
    endtask

    task automatic test_random();
        for (int m = 0; m < 10; m++) begin
            byte unsigned msg[$];
            int len = (m == 0) ? 135 : $urandom_range(0, 300);
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            model(msg);
            exchange(msg, 60);
            total++;
            if (obs_q.size() !== exp_q.size()) begin
                bad++; $display("FAIL rand_count len=%0d got=%0d exp=%0d", len, obs_q.size(), exp_q.size());
            end else begin
                for (int b = 0; b < exp_q.size(); b++) begin
                    total++;
                    if (obs_q[b] !== exp_q[b] || obs_last_q[b] !== exp_last_q[b]) begin
                        bad++; $display("FAIL rand_block len=%0d blk=%0d lane%0d got=%h exp=%h last=%b exp_last=%b", len, b,
                                        first_diff(obs_q[b], exp_q[b]), obs_q[b][first_diff(obs_q[b], exp_q[b])],
                                        exp_q[b][first_diff(obs_q[b], exp_q[b])], obs_last_q[b], exp_last_q[b]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_lane16_pad();
        test_boundary();
        test_backpressure();
        test_reset_midfill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keccak_pad.md
# keccak_pad

Upstream input stage for the `keccak_xor` permutation core. It accepts a little-endian message stream of 64-bit words and packs the words into SHA3-256 rate blocks of 17 lanes (136 bytes). It applies FIPS-202 pad10*1 padding with domain byte 0x06 and presents each finished block as a full 5x5 lane state. Capacity lanes are zero, and a valid/ready handshake gives the core `Din`, `Din_valid` and `Last_block`.

## Interface
- `WIDTH`, default 64: lane width in bits. Only 64 is supported.
- `RATE_LANES`, default 17: rate in lanes. The rate in bytes is `RB = 8*RATE_LANES = 136`.
- `DOMAIN`, default 8'h06: domain-separation byte written at the first pad byte.
- `clk`  in  1  system clock. All state changes on its rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  message word. Byte 0 is bits [7:0].
- `in_bytes`  in  4  count of valid low bytes, 0..8. Used only when `in_last`=1; for other words it is treated as 8.
- `in_valid`  in  1  `in_data`/`in_bytes`/`in_last` are valid.
- `in_last`  in  1  this word ends the message.
- `in_ready`  out  1  the stage accepts a word this cycle.
- `out_block`  out  [0:4][0:4][WIDTH-1:0]  block state. Lane k (0..24) is `out_block[k%5][k/5]`.
- `out_valid`  out  1  `out_block` holds a complete block.
- `out_last`  out  1  the block is the final (padded) block of the message.
- `out_ready`  in  1  the downstream core takes the block this cycle.

## Operation
- Byte placement: message byte j of the current block goes to lane j/8, bits [8*(j%8)+7 : 8*(j%8)]. Lanes 17..24 are always 0.
- Transfer rules:
  - An input transfer occurs when `in_valid` and `in_ready` are both 1.
  - An output transfer occurs when `out_valid` and `out_ready` are both 1.
- State machine:
  - FILL: `in_ready`=1. Each transfer writes `in_data`, masked to its valid bytes, into lane `lane_cnt`, then increments `lane_cnt` (5 bits, 0..16).
  - EMIT: `out_valid`=1 and `in_ready`=0. The block is held stable until the output transfer.
  - PADBLK: an internal one-cycle state that loads a pad-only block.
- Transitions out of FILL:
  - A non-last transfer at `lane_cnt`=16 goes to EMIT with `out_last`=0.
  - A last transfer with b=`in_bytes` sets the pad position p = 8*`lane_cnt`+b. If p<136, padding is applied in the same edge and the state goes to EMIT with `out_last`=1.
  - A last transfer with p=136 (message ends exactly on a block boundary) goes to EMIT with `out_last`=0 and sets the `pad_pending` flag.
- Padding: byte p is set to DOMAIN, and byte 135 is ORed with 0x80. If p=135, that byte is 0x86. Bytes between p and 135 are 0. Masked-off input bytes are 0.
- EMIT exit, on an output transfer:
  - If `pad_pending` is set, go to PADBLK and clear the flag.
  - Otherwise clear the buffer and `lane_cnt` and go to FILL.
- PADBLK: load a block with lane 0 = 0x06 (DOMAIN), lane 16 = 0x8000000000000000 and all other lanes 0. Set `out_last`=1 and go to EMIT.
- Empty message: `in_last`=1 with `in_bytes`=0 at `lane_cnt`=0 gives the single block lane0=0x06, lane16=0x80<<56.
- `in_bytes`>8 on a last word is clamped to 8.

## Timing
- Reset (`nrst`=0, asynchronous), all of the following are 0:
  - the state register, which resets to FILL;
  - `lane_cnt`, `pad_pending` and the buffer;
  - `out_valid`, `out_last` and `out_block`;
  - `in_ready`.
- After reset: `in_ready` is registered and rises on the first `clk` edge after `nrst` deasserts.
- Reset mid-block or mid-EMIT discards everything; no partial block is emitted.
- Latency: `out_valid` rises 1 cycle after the completing input transfer.
- Return to FILL: `in_ready` returns 1 cycle after the output transfer.
- Pad-only block: `out_valid` deasserts for exactly 1 cycle (PADBLK) after the first output transfer, then reasserts.
- Throughput: the minimum is 17 input cycles + 1 EMIT cycle per block when `out_ready` is held at 1.
- Stability: `out_block` and `out_last` are stable while `out_valid`=1 and `out_ready`=0. `out_valid` never drops without an output transfer.
- `in_ready`=0 in EMIT and PADBLK. `in_valid` is ignored while `in_ready`=0.

## Test plan
- Empty message (`in_last`=1, `in_bytes`=0):
  - Required: one block with lane0=0x0000000000000006, lane16=0x8000000000000000 and all other lanes 0.
  - Required: `out_last`=1, `out_valid` 1 cycle after the input transfer.
- "abc" (`in_data`=0x636261, `in_bytes`=3, `in_last`=1):
  - Required: lane0=0x0000000006636261 and lane16=0x8000000000000000.
- 16 full words plus a last word with `in_bytes`=7, data 0x00AABBCCDDEEFF11:
  - Required: lane16=0x86AABBCCDDEEFF11 and `out_last`=1.
- 17 full words with the 17th flagged `in_last`:
  - Required: the first block has `out_last`=0.
  - Required: `out_valid` is low 1 cycle after its output transfer.
  - Required: the second block is lane0=0x06, lane16=0x80<<56, `out_last`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in EMIT while driving `in_valid`=1.
  - Required: `out_block` is unchanged, `in_ready`=0 and no words are consumed.
  - Required: after `out_ready`=1, `in_ready` is 1 the next cycle.
- Reset mid-fill: assert `nrst`=0 after 9 words.
  - Required: all outputs are 0 immediately.
  - Required: a following "abc" message produces exactly the "abc" block above.
